// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester-side and memory-side signals of the shared-memory arbiter
interface mem_access_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 24
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic [2**ADDR_W-1:0]      mem_wl;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, done, rdata, mem_wl, mem_we, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, done, rdata, mem_wl, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter and sequencer for the shared single-port word-line memory
module mem_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 24,
    parameter int RD_LAT  = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_access_arbiter_if.slave bus
);
    localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam int WL_W  = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   win, idx;
    logic               found;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [WL_W-1:0]    wl_q, wl_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    // Round-robin search: first requester after last_q, wrapping
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // IDLE -> ACCESS -> DONE sequencing; mem_we_q doubles as the write flag of the access in flight
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        done_d   = '0;
        rdata_d  = rdata_q;
        wdata_d  = wdata_q;
        wl_d     = wl_q;
        mem_we_d = mem_we_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d    = ACCESS;
                last_d     = win;
                win_d      = win;
                cnt_d      = CNT_W'(RD_LAT - 1);
                gnt_d[win] = 1'b1;
                wl_d       = WL_W'(1) << addr_a[win];
                mem_we_d   = bus.req_we[win];
                wdata_d    = wdata_a[win];
            end
            ACCESS: if (mem_we_q || cnt_q == '0) begin
                state_d       = DONE;
                wl_d          = '0;
                mem_we_d      = 1'b0;
                done_d[win_q] = 1'b1;
                rdata_d       = mem_we_q ? rdata_q : bus.mem_rdata;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight and re-seeds the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDX_W'(NUM_REQ - 1);
            win_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            wl_q     <= '0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            wl_q     <= wl_d;
            mem_we_q <= mem_we_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_wl    = wl_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed vectors plus randomized transactions against a transaction-level model
module tb_mem_access_arbiter;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 24;

    typedef struct {
        logic [N-1:0]  req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [N-1:0]  gnt;
        logic [7:0]    wl;
        logic [DW-1:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a_n, rst_b_n, sel;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   mem_rdata, mem_force;
    logic            use_arr, mem_clr;
    logic [DW-1:0]   mem_arr [8];
    logic [N-1:0]    o_gnt, o_done;
    logic [DW-1:0]   o_rdata, o_wdata;
    logic [7:0]      o_wl;
    logic            o_we;
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [N-1:0]  pend;
    logic          pwe [N];
    logic [AW-1:0] pad [N];
    logic [DW-1:0] pwd [N];
    int            model_last;
    logic [DW-1:0] model_mem [8];
    logic [DW-1:0] model_rdata;

    vec_t va [8];
    vec_t vb [3];
    vec_t v5;

    mem_access_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifa ();
    mem_access_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) ifb ();

    mem_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(ifa));
    mem_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(ifb));

    assign ifa.req = req;
    assign ifa.req_we = req_we;
    assign ifa.req_addr = req_addr;
    assign ifa.req_wdata = req_wdata;
    assign ifa.mem_rdata = mem_rdata;
    assign ifb.req = req;
    assign ifb.req_we = req_we;
    assign ifb.req_addr = req_addr;
    assign ifb.req_wdata = req_wdata;
    assign ifb.mem_rdata = mem_rdata;

    assign o_gnt   = sel ? ifb.gnt : ifa.gnt;
    assign o_done  = sel ? ifb.done : ifa.done;
    assign o_rdata = sel ? ifb.rdata : ifa.rdata;
    assign o_wl    = sel ? ifb.mem_wl : ifa.mem_wl;
    assign o_we    = sel ? ifb.mem_we : ifa.mem_we;
    assign o_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;

    always #5 clk = ~clk;

    function automatic logic [2:0] oh_idx(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    assign mem_rdata = use_arr ? mem_arr[oh_idx(o_wl)] : mem_force;

    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
        else if (o_we && o_wl != 8'h00) mem_arr[oh_idx(o_wl)] <= o_wdata;
    end

    always @(negedge clk) done_cnt <= done_cnt + $countones(o_done);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int lat);
        req    = v.req;
        req_we = {N{v.we}};
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = v.addr;
            req_wdata[i*DW +: DW] = v.data;
        end
        mem_force = ~v.data;
        @(negedge clk);
        chk("vec_gnt", o_gnt, v.gnt);
        chk("vec_wl", o_wl, v.wl);
        chk("vec_we", o_we, v.we);
        if (v.we) chk("vec_wdata", o_wdata, v.data);
        req = '0;
        mem_force = (lat == 1) ? v.data : ~v.data;
        if (!v.we) for (int k = 2; k <= lat; k++) begin
            @(negedge clk);
            chk("vec_wl_hold", o_wl, v.wl);
            chk("vec_early_done", o_done, 0);
            mem_force = (k == lat) ? v.data : v.data ^ 24'h5A5A5A;
        end
        @(negedge clk);
        chk("vec_done", o_done, v.gnt);
        chk("vec_rdata", o_rdata, v.rdata);
        chk("vec_wl_off", o_wl, 0);
        chk("vec_we_off", o_we, 0);
        @(negedge clk);
        chk("vec_idle", {o_done, o_gnt}, 0);
    endtask

    task automatic add_reqs(input int skip, input bit force_one);
        for (int i = 0; i < N; i++) if (!pend[i] && i != skip) begin
            pwe[i] = 1'($urandom_range(0, 1));
            pad[i] = 3'($urandom_range(0, 7));
            pwd[i] = 24'($urandom);
            if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
        end
        if (force_one && pend == '0) pend[$urandom_range(0, N-1)] = 1'b1;
        req = pend;
        for (int i = 0; i < N; i++) begin
            req_we[i]             = pwe[i];
            req_addr[i*AW +: AW]  = pad[i];
            req_wdata[i*DW +: DW] = pwd[i];
        end
    endtask

    task automatic run_rand(input int n, input int lat);
        int win;
        logic c_we;
        logic [AW-1:0] c_a;
        logic [DW-1:0] c_d;
        logic [7:0] c_wl;
        pend = '0;
        model_last = N - 1;
        model_rdata = '0;
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        for (int t = 0; t < n; t++) begin
            add_reqs(-1, 1'b1);
            win = -1;
            for (int k = 1; k <= N; k++)
                if (win < 0 && pend[(model_last + k) % N]) win = (model_last + k) % N;
            c_we = pwe[win];
            c_a  = pad[win];
            c_d  = pwd[win];
            c_wl = 8'd1 << c_a;
            @(negedge clk);
            chk("rnd_gnt", o_gnt, 1 << win);
            chk("rnd_wl", o_wl, c_wl);
            chk("rnd_we", o_we, c_we);
            if (c_we) chk("rnd_wdata", o_wdata, c_d);
            pend[win] = 1'b0;
            if (c_we) model_mem[c_a] = c_d;
            else model_rdata = model_mem[c_a];
            model_last = win;
            add_reqs(win, 1'b0);
            if (!c_we) for (int k = 2; k <= lat; k++) begin
                @(negedge clk);
                chk("rnd_wl_hold", o_wl, c_wl);
                chk("rnd_early_done", o_done, 0);
                add_reqs(-1, 1'b0);
            end
            @(negedge clk);
            chk("rnd_done", o_done, 1 << win);
            chk("rnd_rdata", o_rdata, model_rdata);
            chk("rnd_wl_off", o_wl, 0);
            add_reqs(-1, 1'b0);
            @(negedge clk);
            chk("rnd_idle", {o_done, o_gnt}, 0);
        end
        pend = '0;
        req  = '0;
    endtask

    initial begin
        int cyc, d0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_force = '0; use_arr = 1'b0; mem_clr = 1'b1;
        rst_a_n = 1'b0; rst_b_n = 1'b0; sel = 1'b0;
        va[0] = '{4'b0001, 1'b1, 3'd5, 24'hA5A5A5, 4'b0001, 8'h20, 24'h000000};
        va[1] = '{4'b0100, 1'b0, 3'd2, 24'h123456, 4'b0100, 8'h04, 24'h123456};
        va[2] = '{4'b1001, 1'b0, 3'd0, 24'h0BEEF0, 4'b1000, 8'h01, 24'h0BEEF0};
        va[3] = '{4'b0001, 1'b1, 3'd7, 24'hFFFFFF, 4'b0001, 8'h80, 24'h0BEEF0};
        va[4] = '{4'b1111, 1'b0, 3'd3, 24'hC0FFEE, 4'b0010, 8'h08, 24'hC0FFEE};
        va[5] = '{4'b1111, 1'b1, 3'd6, 24'h112233, 4'b0100, 8'h40, 24'hC0FFEE};
        va[6] = '{4'b0011, 1'b0, 3'd1, 24'h000001, 4'b0001, 8'h02, 24'h000001};
        va[7] = '{4'b0110, 1'b0, 3'd4, 24'hFEDCBA, 4'b0010, 8'h10, 24'hFEDCBA};
        vb[0] = '{4'b0001, 1'b0, 3'd7, 24'hABCDEF, 4'b0001, 8'h80, 24'hABCDEF};
        vb[1] = '{4'b0110, 1'b1, 3'd0, 24'h135790, 4'b0010, 8'h01, 24'hABCDEF};
        vb[2] = '{4'b1100, 1'b0, 3'd4, 24'h2468AC, 4'b0100, 8'h10, 24'h2468AC};
        v5    = '{4'b1010, 1'b0, 3'd5, 24'h5EED01, 4'b0010, 8'h20, 24'h5EED01};
        repeat (2) @(negedge clk);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_done", o_done, 0);
        chk("rst_wl", o_wl, 0);
        chk("rst_we", o_we, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_wdata", o_wdata, 0);
        rst_a_n = 1'b1;
        mem_clr = 1'b0;
        for (int i = 0; i < 8; i++) run_vec(va[i], 1);
        rst_a_n = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1;
        req_we = '1;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = 3'(i + 1);
            req_wdata[i*DW +: DW] = 24'(i * 1000 + 7);
        end
        req = 4'b1111;
        d0 = done_cnt;
        for (int g = 0; g < N; g++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (o_gnt == '0 && cyc < 8);
            chk("all4_order", o_gnt, 1 << g);
            chk("all4_gap", cyc, g == 0 ? 1 : 3);
            req[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("all4_done_count", done_cnt - d0, 4);
        rst_a_n = 1'b0;
        mem_clr = 1'b1;
        use_arr = 1'b1;
        @(negedge clk);
        rst_a_n = 1'b1;
        mem_clr = 1'b0;
        run_rand(60, 1);
        rst_a_n = 1'b0;
        sel = 1'b1;
        use_arr = 1'b0;
        @(negedge clk);
        chk("rst_b_wl", o_wl, 0);
        chk("rst_b_rdata", o_rdata, 0);
        rst_b_n = 1'b1;
        for (int i = 0; i < 3; i++) run_vec(vb[i], 3);
        req = 4'b0100;
        req_we = '0;
        @(negedge clk);
        chk("abort_gnt", o_gnt, 4'b0100);
        req = '0;
        @(negedge clk);
        d0 = done_cnt;
        rst_b_n = 1'b0;
        #1;
        chk("abort_wl", o_wl, 0);
        chk("abort_gnt_off", o_gnt, 0);
        chk("abort_done", o_done, 0);
        chk("abort_we", o_we, 0);
        chk("abort_rdata", o_rdata, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        rst_b_n = 1'b1;
        run_vec(v5, 3);
        rst_b_n = 1'b0;
        mem_clr = 1'b1;
        use_arr = 1'b1;
        @(negedge clk);
        rst_b_n = 1'b1;
        mem_clr = 1'b0;
        run_rand(40, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
